float_result_queue: RTL and testbench

- Downstream stage of float_alu: accepts {result, flags} on the ALU's valid_out/ready_in handshake and buffers them in a small FIFO for the consumer (register-file writeback / host interface).
- Maintains an IEEE-style sticky exception register that accumulates every accepted flags word until the consumer clears it.
- Decouples ALU completion from consumer stalls. alu_ready drives float_alu.ready_in directly.

---
 rtl/float_alu_pkg.sv | 16 +
 rtl/float_result_queue_if.sv | 30 +++
 rtl/float_result_queue_fifo.sv | 46 ++++
 rtl/float_result_queue.sv | 44 ++++
 tb/tb_float_result_queue.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/float_alu_pkg.sv
// Shared float_alu types: flag layout {X,Z,O,U,I} and the result+flags entry.
package float_alu_pkg;
    localparam int DATA_W = 32;
    localparam int FLAG_W = 5;

    localparam int FLAG_X = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_U = 1;
    localparam int FLAG_I = 0;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;
    } entry_t;
endpackage

// File: rtl/float_result_queue_if.sv
// ALU-side and consumer-side handshake bundle of float_result_queue.
interface float_result_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = float_alu_pkg::DATA_W,
    parameter int FLAG_W = float_alu_pkg::FLAG_W
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic [DATA_W-1:0] alu_result;
    logic [FLAG_W-1:0] alu_flags;
    logic              alu_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [FLAG_W-1:0] out_flags;
    logic [FLAG_W-1:0] sticky_flags;
    logic              sticky_clr;
    logic [CW-1:0]     count;

    modport slave (
        input  alu_valid, alu_result, alu_flags, out_ready, sticky_clr,
        output alu_ready, out_valid, out_result, out_flags, sticky_flags, count
    );

    modport master (
        output alu_valid, alu_result, alu_flags, out_ready, sticky_clr,
        input  alu_ready, out_valid, out_result, out_flags, sticky_flags, count
    );
endinterface

// File: rtl/float_result_queue_fifo.sv
// Generic first-word-fall-through FIFO; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy register.
module float_fifo
    import float_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_W + FLAG_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero while empty so stale storage never leaks out.
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/float_result_queue.sv
// Result buffer behind float_alu: FWFT FIFO of {result, flags} plus a sticky
// exception register accumulating the flags of every accepted entry.
module float_result_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = float_alu_pkg::DATA_W,
    parameter int FLAG_W = float_alu_pkg::FLAG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    float_result_queue_if.slave   bus
);
    localparam int W = DATA_W + FLAG_W;

    logic              push, pop, full, empty;
    logic [W-1:0]      rd_entry;
    logic [FLAG_W-1:0] sticky;

    // alu_ready depends only on registered pointers, so no pop-through when full.
    assign bus.alu_ready = !full;
    assign push          = bus.alu_valid && !full;
    assign pop           = bus.out_ready && !empty;

    float_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({bus.alu_result, bus.alu_flags}),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty),
        .count (bus.count)
    );

    assign bus.out_valid                   = !empty;
    assign {bus.out_result, bus.out_flags} = rd_entry;
    assign bus.sticky_flags                = sticky;

    // Clear wins over old state but not over flags arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky <= '0;
        else        sticky <= (bus.sticky_clr ? '0 : sticky) | (push ? bus.alu_flags : '0);
    end
endmodule

// File: tb/tb_float_result_queue.sv
// Self-checking bench for float_result_queue against a queue-based model.
module tb_float_result_queue;
    import float_alu_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    entry_t      m_q[$];
    logic [4:0]  m_sticky = '0;

    always #5 clk = ~clk;

    float_result_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .FLAG_W(5)) bus ();

    float_result_queue #(.DEPTH(DEPTH), .DATA_W(32), .FLAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] m_res();
        return (m_q.size() > 0) ? m_q[0].result : 32'h0;
    endfunction

    function automatic logic [4:0] m_flg();
        return (m_q.size() > 0) ? m_q[0].flags : 5'h0;
    endfunction

    function automatic logic [2:0] m_cnt();
        return 3'(m_q.size());
    endfunction

    // Drive one cycle from a negedge, advance the model at posedge, return at negedge.
    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] f,
                         input logic ordy, input logic clr);
        logic acc;
        entry_t e;
        bus.alu_valid  = v;
        bus.alu_result = r;
        bus.alu_flags  = f;
        bus.out_ready  = ordy;
        bus.sticky_clr = clr;
        @(posedge clk);
        acc = v && (m_q.size() < DEPTH);
        if (ordy && m_q.size() > 0) void'(m_q.pop_front());
        if (acc) begin
            e.result = r;
            e.flags  = f;
            m_q.push_back(e);
        end
        m_sticky = (clr ? 5'h0 : m_sticky) | (acc ? f : 5'h0);
        @(negedge clk);
        bus.alu_valid  = 1'b0;
        bus.out_ready  = 1'b0;
        bus.sticky_clr = 1'b0;
    endtask

    task automatic test_reset();
        bus.alu_valid = 0; bus.alu_result = '0; bus.alu_flags = '0;
        bus.out_ready = 0; bus.sticky_clr = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_sticky = '0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL reset_alu_ready got=%b exp=1", bus.alu_ready); end
        checks++; if (bus.sticky_flags !== 5'h0) begin failures++; $display("FAIL reset_sticky got=%b exp=00000", bus.sticky_flags); end
        checks++; if ({bus.out_result, bus.out_flags} !== 37'h0) begin failures++; $display("FAIL reset_out_data got=%h/%b exp=0", bus.out_result, bus.out_flags); end
    endtask

    task automatic test_single();
        bus.alu_valid = 1; bus.alu_result = 32'h41B8_0000; bus.alu_flags = 5'b00000;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", bus.out_valid); end
        drive(1, 32'h41B8_0000, 5'b00000, 0, 0);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_result !== 32'h41B8_0000) begin failures++; $display("FAIL single_result got=%h exp=41b80000", bus.out_result); end
        checks++; if (bus.out_flags !== 5'b00000) begin failures++; $display("FAIL single_flags got=%b exp=00000", bus.out_flags); end
        checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.count); end
        drive(0, 32'h0, 5'h0, 1, 0);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_full();
        logic [31:0] res [5];
        logic [4:0]  flg [5];
        res = '{32'h3E99_999A, 32'h7F80_0000, 32'h3FE0_0000, 32'h40BB_8417, 32'h41B8_0000};
        flg = '{5'b00001, 5'b00101, 5'b00000, 5'b00001, 5'b00000};
        for (int i = 0; i < 4; i++) drive(1, res[i], flg[i], 0, 0);
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", bus.count); end
        checks++; if (bus.alu_ready !== 1'b0) begin failures++; $display("FAIL full_alu_ready got=%b exp=0", bus.alu_ready); end
        for (int i = 0; i < 3; i++) begin
            drive(1, res[4], flg[4], 0, 0);
            checks++; if (bus.count !== 3'd4 || bus.alu_ready !== 1'b0) begin failures++; $display("FAIL full_hold got=%0d/%b exp=4/0", bus.count, bus.alu_ready); end
        end
        checks++; if (bus.out_result !== res[0] || bus.out_flags !== flg[0]) begin failures++; $display("FAIL full_head got=%h/%b exp=%h/%b", bus.out_result, bus.out_flags, res[0], flg[0]); end
        drive(1, res[4], flg[4], 1, 0);
        checks++; if (bus.alu_ready !== 1'b1 || bus.count !== 3'd3) begin failures++; $display("FAIL full_pop_frees got=%b/%0d exp=1/3", bus.alu_ready, bus.count); end
        drive(1, res[4], flg[4], 0, 0);
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL full_fifth_accept got=%0d exp=4", bus.count); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== res[i] || bus.out_flags !== flg[i]) begin
                failures++; $display("FAIL full_drain%0d got=%b/%h/%b exp=1/%h/%b", i, bus.out_valid, bus.out_result, bus.out_flags, res[i], flg[i]);
            end
            drive(0, 32'h0, 5'h0, 1, 0);
        end
        checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin failures++; $display("FAIL full_drained got=%b/%0d exp=0/0", bus.out_valid, bus.count); end
    endtask

    task automatic test_push_pop();
        drive(1, 32'hAAAA_0001, 5'b00010, 0, 0);
        drive(1, 32'hAAAA_0002, 5'b01000, 0, 0);
        drive(1, 32'hAAAA_0003, 5'b10000, 1, 0);
        checks++; if (bus.count !== 3'd2) begin failures++; $display("FAIL pushpop_count got=%0d exp=2", bus.count); end
        checks++; if (bus.out_result !== 32'hAAAA_0002 || bus.out_flags !== 5'b01000) begin failures++; $display("FAIL pushpop_head got=%h/%b exp=aaaa0002/01000", bus.out_result, bus.out_flags); end
        repeat (2) drive(0, 32'h0, 5'h0, 1, 0);
        drive(0, 32'h0, 5'h0, 1, 0);
        checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL pushpop_empty_pop got=%0d/%b exp=0/0", bus.count, bus.out_valid); end
    endtask

    task automatic test_sticky();
        drive(0, 32'h0, 5'h0, 0, 1);
        checks++; if (bus.sticky_flags !== 5'b00000) begin failures++; $display("FAIL sticky_clr got=%b exp=00000", bus.sticky_flags); end
        drive(1, 32'h1111_1111, 5'b00001, 0, 0);
        drive(1, 32'h2222_2222, 5'b00100, 0, 0);
        checks++; if (bus.sticky_flags !== 5'b00101) begin failures++; $display("FAIL sticky_accum got=%b exp=00101", bus.sticky_flags); end
        drive(1, 32'h3333_3333, 5'b10000, 0, 1);
        checks++; if (bus.sticky_flags !== 5'b10000) begin failures++; $display("FAIL sticky_clr_push got=%b exp=10000", bus.sticky_flags); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 5'h0, 1, 0);
            checks++; if (bus.sticky_flags !== 5'b10000) begin failures++; $display("FAIL sticky_pop%0d got=%b exp=10000", i, bus.sticky_flags); end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 32'h0, 5'h0, 0, 1);
        drive(1, 32'h5000_0001, 5'b00001, 0, 0);
        drive(1, 32'h5000_0002, 5'b00010, 0, 0);
        drive(1, 32'h5000_0003, 5'b00100, 0, 0);
        checks++; if (bus.count !== 3'd3 || bus.sticky_flags !== 5'b00111) begin failures++; $display("FAIL rstmid_pre got=%0d/%b exp=3/00111", bus.count, bus.sticky_flags); end
        #2 rst_n = 1'b0;
        #1;
        m_q.delete();
        m_sticky = '0;
        checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin failures++; $display("FAIL rstmid_state got=%b/%0d exp=0/0", bus.out_valid, bus.count); end
        checks++; if (bus.sticky_flags !== 5'b0 || bus.alu_ready !== 1'b1) begin failures++; $display("FAIL rstmid_sticky_ready got=%b/%b exp=00000/1", bus.sticky_flags, bus.alu_ready); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        drive(1, 32'h4010_0000, 5'b00000, 0, 0);
        checks++; if (bus.count !== 3'd1 || bus.out_result !== 32'h4010_0000) begin failures++; $display("FAIL rstmid_first got=%0d/%h exp=1/40100000", bus.count, bus.out_result); end
        drive(0, 32'h0, 5'h0, 1, 0);
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        logic [4:0]  f;
        for (int i = 0; i < 10; i++) begin
            v = $urandom;
            f = 5'($urandom);
            drive(1, v, f, 0, 0);
            checks++; if (bus.out_valid !== 1'b1 || bus.alu_ready !== 1'b1 || bus.count !== 3'd1) begin
                failures++; $display("FAIL wrap%0d_flags got=%b/%b/%0d exp=1/1/1", i, bus.out_valid, bus.alu_ready, bus.count);
            end
            checks++; if (bus.out_result !== v || bus.out_flags !== f) begin failures++; $display("FAIL wrap%0d_data got=%h/%b exp=%h/%b", i, bus.out_result, bus.out_flags, v, f); end
            drive(0, 32'h0, 5'h0, 1, 0);
            checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin failures++; $display("FAIL wrap%0d_empty got=%b/%0d exp=0/0", i, bus.out_valid, bus.count); end
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            checks++;
            if (bus.count !== m_cnt() || bus.out_valid !== (m_q.size() > 0) ||
                bus.alu_ready !== (m_q.size() < DEPTH) || bus.out_result !== m_res() ||
                bus.out_flags !== m_flg() || bus.sticky_flags !== m_sticky) begin
                failures++;
                if (errs < 10) $display("FAIL random%0d got=%0d/%b/%b/%h/%b/%b exp=%0d/%b/%b/%h/%b/%b", i,
                    bus.count, bus.out_valid, bus.alu_ready, bus.out_result, bus.out_flags, bus.sticky_flags,
                    m_cnt(), m_q.size() > 0, m_q.size() < DEPTH, m_res(), m_flg(), m_sticky);
                errs++;
            end
            drive(($urandom_range(0, 9) < 7), $urandom, 5'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_push_pop();
        test_sticky();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
